uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions (receiver and transmitter): counter width
//            and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Width of the per-bit cycle counter; matches the divider port width.
  localparam int COUNT_REG_LEN = 10;

  // FSM state encodings.
  localparam int         c_state_w    = 2;
  localparam logic [1:0] c_state_idle  = 2'd0;
  localparam logic [1:0] c_state_start = 2'd1;
  localparam logic [1:0] c_state_recv  = 2'd2;
  localparam logic [1:0] c_state_stop  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync2
// Purpose  : Two-flop synchronizer for an asynchronous single-bit input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; reset value matches the idle level of the line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver, 1 start bit, PAYLOAD_BITS data bits (LSB first),
//            1 stop bit. Bit period is divider+1 clock cycles. Reports good
//            frames, framing errors and break conditions as one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [9:0]              divider,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam logic [3:0] c_last_bit = 4'(PAYLOAD_BITS - 1);

  logic                     w_rxd;
  logic [c_state_w-1:0]     r_state;
  logic [c_state_w-1:0]     w_state_next;
  logic [COUNT_REG_LEN-1:0] r_cycle_cnt;
  logic [3:0]               r_bit_cnt;
  logic [PAYLOAD_BITS-1:0]  r_shift;
  logic [PAYLOAD_BITS-1:0]  w_shift_next;

  logic w_half_hit;
  logic w_full_hit;
  logic w_last_bit;
  logic w_cnt_clear;
  logic w_bit_sample;
  logic w_stop_sample;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (w_rxd)
  );

  assign w_half_hit = (r_cycle_cnt == (divider >> 1));
  assign w_full_hit = (r_cycle_cnt == divider);
  assign w_last_bit = (r_bit_cnt == c_last_bit);

  // New bits enter at the MSB so the first bit on the line ends in bit 0.
  generate
    if (PAYLOAD_BITS == 1) begin : g_shift_single
      assign w_shift_next = w_rxd;
    end else begin : g_shift_multi
      assign w_shift_next = {w_rxd, r_shift[PAYLOAD_BITS-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_state_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping the enable aborts any frame in progress.
  always_comb begin
    w_state_next = r_state;
    if (!uart_rx_en) begin
      w_state_next = c_state_idle;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (!w_rxd) w_state_next = c_state_start;
        end
        c_state_start: begin
          if (w_half_hit) w_state_next = w_rxd ? c_state_idle : c_state_recv;
        end
        c_state_recv: begin
          if (w_full_hit && w_last_bit) w_state_next = c_state_stop;
        end
        c_state_stop: begin
          if (w_full_hit) w_state_next = c_state_idle;
        end
        default: w_state_next = c_state_idle;
      endcase
    end
  end

  // Per-state control strobes for counters, shifter and result registers.
  always_comb begin
    w_cnt_clear   = 1'b1;
    w_bit_sample  = 1'b0;
    w_stop_sample = 1'b0;
    if (uart_rx_en) begin
      case (r_state)
        c_state_start: w_cnt_clear = w_half_hit;
        c_state_recv: begin
          w_cnt_clear  = w_full_hit;
          w_bit_sample = w_full_hit;
        end
        c_state_stop: begin
          w_cnt_clear   = w_full_hit;
          w_stop_sample = w_full_hit;
        end
        default: w_cnt_clear = 1'b1;
      endcase
    end
  end

  // Cycle counter within the current bit period.
  always_ff @(posedge clk) begin
    if (!resetn || w_cnt_clear) begin
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  // Data-bit counter; returns to zero on the final sample (entry to STOP).
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en || (r_state != c_state_recv)) begin
      r_bit_cnt <= '0;
    end else if (w_bit_sample) begin
      r_bit_cnt <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
    end
  end

  // Payload shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shift <= '0;
    end else if (w_bit_sample) begin
      r_shift <= w_shift_next;
    end
  end

  // Result pulses and payload hold register, updated on the stop-bit sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_data      <= '0;
    end else begin
      uart_rx_valid     <= w_stop_sample & w_rxd;
      uart_rx_frame_err <= w_stop_sample & ~w_rxd;
      uart_rx_break     <= w_stop_sample & ~w_rxd & (r_shift == '0);
      if (w_stop_sample) uart_rx_data <= r_shift;
    end
  end

endmodule
`default_nettype wire
